// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: S1 captures a field beat with its word
// address, S2 holds the packed 32-bit instruction, address and error flag.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        err
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Immediate fits when every bit above 'top' matches the sign bit imm[top].
    function automatic logic sext_ok_f(input logic [31:0] im, input int unsigned top);
        logic [31:0] hi;
        hi = $signed(im) >>> top;
        return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
    endfunction

    // Returns {err, instr}; any error replaces the word with a NOP.
    function automatic logic [32:0] encode_f(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  rd_v,
        input logic [4:0]  rs1_v,
        input logic [4:0]  rs2_v,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        logic [31:0] word;
        logic        bad;
        word = NOP;
        bad  = 1'b0;
        case (f)
            3'd0: word = {f7, rs2_v, rs1_v, f3, rd_v, op};
            3'd1: begin
                word = {im[11:0], rs1_v, f3, rd_v, op};
                bad  = !sext_ok_f(im, 32'd11);
            end
            3'd2: begin
                word = {im[11:5], rs2_v, rs1_v, f3, im[4:0], op};
                bad  = !sext_ok_f(im, 32'd11);
            end
            3'd3: begin
                word = {im[12], im[10:5], rs2_v, rs1_v, f3, im[4:1], im[11], op};
                bad  = im[0] || !sext_ok_f(im, 32'd12);
            end
            3'd4: begin
                word = {im[31:12], rd_v, op};
                bad  = (im[11:0] != 12'h000);
            end
            3'd5: begin
                word = {im[20], im[10:1], im[11], im[19:12], rd_v, op};
                bad  = im[0] || !sext_ok_f(im, 32'd20);
            end
            default: bad = 1'b1;
        endcase
        return {bad, (bad ? NOP : word)};
    endfunction

    logic        ready_en_r;
    logic        s1_valid_r;
    logic [2:0]  s1_fmt_r;
    logic [6:0]  s1_opcode_r;
    logic [4:0]  s1_rd_r;
    logic [4:0]  s1_rs1_r;
    logic [4:0]  s1_rs2_r;
    logic [2:0]  s1_funct3_r;
    logic [6:0]  s1_funct7_r;
    logic [31:0] s1_imm_r;
    logic [31:0] s1_addr_r;
    logic [31:0] addr_cnt_r;
    logic        s1_adv_s;
    logic        accept_s;
    logic [32:0] enc_s;

    // ready_en_r keeps in_ready low until the first edge after reset release.
    assign s1_adv_s = !out_valid || out_ready;
    assign in_ready = ready_en_r && (!s1_valid_r || s1_adv_s);
    assign accept_s = in_valid && in_ready;
    assign enc_s    = encode_f(s1_fmt_r, s1_opcode_r, s1_rd_r, s1_rs1_r, s1_rs2_r,
                               s1_funct3_r, s1_funct7_r, s1_imm_r);

    // S1 capture stage and the per-beat address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_r  <= 1'b0;
            s1_valid_r  <= 1'b0;
            s1_fmt_r    <= 3'd0;
            s1_opcode_r <= 7'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_funct3_r <= 3'd0;
            s1_funct7_r <= 7'd0;
            s1_imm_r    <= 32'd0;
            s1_addr_r   <= BASE_ADDR;
            addr_cnt_r  <= BASE_ADDR;
        end else begin
            ready_en_r <= 1'b1;
            if (in_ready) begin
                s1_valid_r <= in_valid;
            end
            if (accept_s) begin
                s1_fmt_r    <= fmt;
                s1_opcode_r <= opcode;
                s1_rd_r     <= rd;
                s1_rs1_r    <= rs1;
                s1_rs2_r    <= rs2;
                s1_funct3_r <= funct3;
                s1_funct7_r <= funct7;
                s1_imm_r    <= imm;
                s1_addr_r   <= addr_cnt_r;
                addr_cnt_r  <= addr_cnt_r + 32'd4;
            end
        end
    end

    // S2 output register; holds its beat while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            instr     <= 32'd0;
            addr      <= BASE_ADDR;
            err       <= 1'b0;
        end else if (s1_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                instr <= enc_s[31:0];
                err   <= enc_s[32];
                addr  <= s1_addr_r;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// run scored against an arithmetic reference model.
module tb_instr_encoder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic        in_ready_w;
    logic        out_valid_w;
    logic [31:0] instr_w;
    logic [31:0] addr_w;
    logic        err_w;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .addr(addr), .err(err)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .instr(instr_w), .addr(addr_w), .err(err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder built from field positions with shifts and signed ranges.
    function automatic logic [32:0] model_f(
        input logic [2:0] f, input logic [6:0] op, input logic [4:0] rdv,
        input logic [4:0] rs1v, input logic [4:0] rs2v, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] im
    );
        logic [31:0] o, d, t, r1, r2, w;
        int s;
        bit ok;
        s  = $signed(im);
        o  = 32'(op);
        d  = 32'(rdv) << 7;
        t  = 32'(f3) << 12;
        r1 = 32'(rs1v) << 15;
        r2 = 32'(rs2v) << 20;
        case (f)
            3'd0: begin ok = 1'b1; w = o | d | t | r1 | r2 | (32'(f7) << 25); end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = o | d | t | r1 | ((im & 32'hFFF) << 20);
            end
            3'd2: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = o | ((im & 32'h1F) << 7) | t | r1 | r2 | (((im >> 5) & 32'h7F) << 25);
            end
            3'd3: begin
                ok = ((im & 32'd1) == 32'd0) && (s >= -4096) && (s <= 4094);
                w  = o | (((im >> 11) & 32'd1) << 7) | (((im >> 1) & 32'hF) << 8) | t | r1 | r2
                     | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'd1) << 31);
            end
            3'd4: begin ok = ((im & 32'hFFF) == 32'd0); w = o | d | (im & 32'hFFFF_F000); end
            3'd5: begin
                ok = ((im & 32'd1) == 32'd0) && (s >= -1048576) && (s <= 1048574);
                w  = o | d | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'd1) << 20)
                     | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'd1) << 31);
            end
            default: begin ok = 1'b0; w = 32'd0; end
        endcase
        if (!ok) w = 32'h0000_0013;
        return {!ok, w};
    endfunction

    task automatic drive_beat(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rdv,
                              input logic [4:0] rs1v, input logic [4:0] rs2v, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im);
        in_valid = 1'b1; fmt = f; opcode = op; rd = rdv; rs1 = rs1v; rs2 = rs2v;
        funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_checks++; if ({err, instr, addr} !== 65'd0) begin n_fail++; $display("FAIL rst_outputs: got err=%0b instr=%h addr=%h want 0/0/0", err, instr, addr); end
        n_checks++; if (addr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_base_addr: got %h want fffffffc", addr_w); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_hold_ready: got %0b want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready: got %0b want 0", in_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_edge_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_i_format();
        apply_reset();
        @(negedge clk);
        drive_beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL i_latency: got out_valid=%0b want 0 after one cycle", out_valid); end
        @(negedge clk);
        n_checks++; if ({out_valid, err, instr, addr} !== {1'b1, 1'b0, 32'hFFF0_0093, 32'h0})
            begin n_fail++; $display("FAIL i_encode: got v=%0b err=%0b instr=%h addr=%h want 1/0/fff00093/0", out_valid, err, instr, addr); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        drive_beat(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        @(negedge clk);
        drive_beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if ({out_valid, err, instr, addr} !== {1'b1, 1'b0, 32'h0020_A423, 32'h0})
            begin n_fail++; $display("FAIL b2b_sw: got v=%0b err=%0b instr=%h addr=%h want 1/0/0020a423/0", out_valid, err, instr, addr); end
        @(negedge clk);
        n_checks++; if ({out_valid, err, instr, addr} !== {1'b1, 1'b0, 32'h0020_8463, 32'h4})
            begin n_fail++; $display("FAIL b2b_beq: got v=%0b err=%0b instr=%h addr=%h want 1/0/00208463/4", out_valid, err, instr, addr); end
    endtask

    task automatic test_j_err();
        apply_reset();
        @(negedge clk);
        drive_beat(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        @(negedge clk);
        drive_beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if ({out_valid, err, instr, addr} !== {1'b1, 1'b0, 32'h0010_00EF, 32'h0})
            begin n_fail++; $display("FAIL j_encode: got v=%0b err=%0b instr=%h addr=%h want 1/0/001000ef/0", out_valid, err, instr, addr); end
        @(negedge clk);
        drive_beat(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        n_checks++; if ({out_valid, err, instr, addr} !== {1'b1, 1'b1, 32'h0000_0013, 32'h4})
            begin n_fail++; $display("FAIL b_odd_err: got v=%0b err=%0b instr=%h addr=%h want 1/1/00000013/4", out_valid, err, instr, addr); end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, err, instr, addr} !== {1'b1, 1'b0, 32'h0031_00B3, 32'h8})
            begin n_fail++; $display("FAIL after_err_addr: got v=%0b err=%0b instr=%h addr=%h want 1/0/003100b3/8", out_valid, err, instr, addr); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        out_ready = 1'b0;
        drive_beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        drive_beat(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second_ready: got %0b want 1", in_ready); end
        @(negedge clk);
        drive_beat(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %0b want 0 (cycle %0d)", in_ready, k); end
            n_checks++; if ({out_valid, err, instr, addr} !== {1'b1, 1'b0, 32'h0010_0093, 32'h0})
                begin n_fail++; $display("FAIL bp_stall_hold: got v=%0b err=%0b instr=%h addr=%h want 1/0/00100093/0", out_valid, err, instr, addr); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        n_checks++; if ({out_valid, instr, addr} !== {1'b1, 32'h0010_0093, 32'h0})
            begin n_fail++; $display("FAIL bp_beat0: got v=%0b instr=%h addr=%h want 1/00100093/0", out_valid, instr, addr); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if ({out_valid, instr, addr} !== {1'b1, 32'h0020_0113, 32'h4})
            begin n_fail++; $display("FAIL bp_beat1: got v=%0b instr=%h addr=%h want 1/00200113/4", out_valid, instr, addr); end
        @(negedge clk);
        n_checks++; if ({out_valid, instr, addr} !== {1'b1, 32'h0030_0193, 32'h8})
            begin n_fail++; $display("FAIL bp_beat2: got v=%0b instr=%h addr=%h want 1/00300193/8", out_valid, instr, addr); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got out_valid=%0b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk);
        drive_beat(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        @(negedge clk);
        drive_beat(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({out_valid, in_ready, addr} !== {1'b0, 1'b0, 32'h0})
            begin n_fail++; $display("FAIL async_rst: got v=%0b rdy=%0b addr=%h want 0/0/0", out_valid, in_ready, addr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_ghost1: got out_valid=%0b want 0", out_valid); end
        drive_beat(3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_ghost2: got out_valid=%0b want 0", out_valid); end
        @(negedge clk);
        n_checks++; if ({out_valid, instr, addr} !== {1'b1, 32'h0060_0313, 32'h0})
            begin n_fail++; $display("FAIL async_next_beat: got v=%0b instr=%h addr=%h want 1/00600313/0", out_valid, instr, addr); end
    endtask

    task automatic test_wrap();
        apply_reset();
        @(negedge clk);
        drive_beat(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        @(negedge clk);
        drive_beat(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if ({out_valid_w, instr_w, addr_w} !== {1'b1, 32'h1234_50B7, 32'hFFFF_FFFC})
            begin n_fail++; $display("FAIL wrap_first: got v=%0b instr=%h addr=%h want 1/123450b7/fffffffc", out_valid_w, instr_w, addr_w); end
        @(negedge clk);
        n_checks++; if ({out_valid_w, instr_w, addr_w} !== {1'b1, 32'h0000_1137, 32'h0})
            begin n_fail++; $display("FAIL wrap_second: got v=%0b instr=%h addr=%h want 1/00001137/0", out_valid_w, instr_w, addr_w); end
    endtask

    task automatic test_random();
        logic [64:0] exp_q[$];
        logic [64:0] exp_v;
        logic [64:0] held;
        logic [32:0] m;
        logic [31:0] next_addr;
        bit          held_v;
        int          bnd[12] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, -4098,
                                  1048574, -1048576, 1048576, 4095};
        next_addr = 32'h0;
        held_v    = 1'b0;
        held      = 65'd0;
        apply_reset();
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (cyc < 600) begin
                in_valid = ($urandom_range(0, 3) != 0);
                fmt = 3'($urandom_range(0, 7)); opcode = 7'($urandom); rd = 5'($urandom);
                rs1 = 5'($urandom); rs2 = 5'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
                case ($urandom_range(0, 3))
                    0: imm = $urandom;
                    1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                    2: imm = $urandom & 32'hFFFF_F000;
                    default: imm = 32'(bnd[$urandom_range(0, 11)]) ^ 32'($urandom_range(0, 1));
                endcase
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (held_v) begin
                n_checks++;
                if ({out_valid, err, addr, instr} !== {1'b1, held})
                    begin n_fail++; $display("FAIL rnd_stall_hold: got v=%0b err=%0b addr=%h instr=%h want held %h", out_valid, err, addr, instr, held); end
            end
            if (in_valid && in_ready) begin
                m = model_f(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                exp_q.push_back({m[32], next_addr, m[31:0]});
                next_addr = next_addr + 32'd4;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_unexpected: got beat addr=%h instr=%h with none expected", addr, instr);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({err, addr, instr} !== exp_v)
                        begin n_fail++; $display("FAIL rnd_beat: got err=%0b addr=%h instr=%h want %h", err, addr, instr, exp_v); end
                end
            end
            held_v = out_valid && !out_ready;
            held   = {err, addr, instr};
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d beats missing want 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
        test_reset();
        test_i_format();
        test_back_to_back();
        test_j_err();
        test_backpressure();
        test_async_reset();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, first instruction-memory word address after reset.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have: rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have: in_valid  input  1, in_ready  output  1  input handshake.
REQ-005 SHALL have: fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 illegal.
REQ-006 SHALL have: opcode input 7, rd input 5, rs1 input 5, rs2 input 5, funct3 input 3, funct7 input 7  instruction fields.
REQ-007 SHALL have: imm  input  32  signed byte-level immediate value to pack.
REQ-008 SHALL have: out_valid  output  1, out_ready  input  1  output handshake.
REQ-009 SHALL have: instr output 32 encoded word; addr output 32 word address; err output 1 encode error flag for the current beat.

Function
REQ-010 SHALL accept a beat when in_valid && in_ready; inputs are sampled only then.
REQ-011 SHALL be a 2-stage pipeline (S1 capture, S2 encoded output register); latency 2 cycles from accept to out_valid when not stalled.
REQ-012 SHALL sustain 1 beat/cycle while out_ready is high.
REQ-013 in_ready SHALL be high when S1 is empty or S1 advances this cycle; S1 advances when S2 is empty or out_ready is high.
REQ-014 SHALL hold out_valid, instr, addr and err stable while out_valid && !out_ready; no beat SHALL be lost, duplicated or reordered.
REQ-015 R: instr = {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored; err=0.
REQ-016 I: {imm[11:0], rs1, funct3, rd, opcode}; err if imm outside -2048..2047.
REQ-017 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; same range as I.
REQ-018 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; err if imm[0]=1 or imm outside -4096..4094.
REQ-019 U: {imm[31:12], rd, opcode}; err if imm[11:0] != 0.
REQ-020 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; err if imm[0]=1 or imm outside -1048576..1048574.
REQ-021 Illegal fmt or any range error SHALL set err=1 and emit instr=32'h0000_0013 (NOP) for that beat.
REQ-022 Range checks SHALL be signed: the upper imm bits must equal the sign-extension of the field's top bit.
REQ-023 Internal address counter SHALL be assigned to each beat at accept and then incremented by 4, including error beats.
REQ-024 Address counter SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without a flag.
REQ-025 addr SHALL travel with its beat through both stages.

Reset
REQ-026 While rst is high: in_ready=0, out_valid=0, instr=0, err=0, addr=BASE_ADDR, counter=BASE_ADDR, both stages empty.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after release.
REQ-028 in_ready SHALL go high on the first rising edge after rst deasserts.

Verification
REQ-029 I: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> 2 cycles later instr=0xFFF00093, addr=0x0, err=0.
REQ-030 S then B back-to-back, out_ready=1. sw: opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423, addr=0x0. beq: opcode=0x63, funct3=0, rs1=1, rs2=2, imm=8 -> 0x00208463, addr=0x4, consecutive cycles.
REQ-031 J: fmt=5, opcode=0x6F, rd=1, imm=0x800 -> instr=0x001000EF. Then B with imm=5 -> instr=0x00000013, err=1, addr still advances by 4.
REQ-032 Backpressure: 3 beats while out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted; on release outputs emerge in order at addr 0x0, 0x4, 0x8, stable while stalled.
REQ-033 Reset: assert rst asynchronously with 2 beats in flight -> out_valid=0 immediately. After release, the next beat has addr=BASE_ADDR.
REQ-034 Wrap: BASE_ADDR=32'hFFFF_FFFC, 2 beats -> addr 0xFFFFFFFC then 0x00000000.
